// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Definitions shared by fifo_mem and its stream-drain consumer.
//   - FIFO_DATA_WIDTH : default data width of fifo_mem data_out and stream data
//   - drain_state_e   : drain controller states
//   - occ_width()     : bits needed to hold an occupancy count of 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf
//   Small circular buffer that absorbs words popped from fifo_mem while the
//   stream sink applies back-pressure. Push and pop may occur in the same
//   cycle; order is always preserved.
// Ports
//   clk_in       in   1           clock, rising edge
//   areset_b     in   1           asynchronous active-low reset
//   i_push       in   1           write i_push_data at the tail
//   i_push_data  in   DATA_WIDTH  word to store
//   i_pop        in   1           drop the head word
//   o_occ        out  OCC_W       number of words held
//   o_head       out  DATA_WIDTH  head word (meaningful only when o_occ != 0)
// ---------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int SKID_DEPTH = 2,
    localparam int OCC_W     = occ_width(SKID_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [OCC_W-1:0]      o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy alone
    // says which entries are valid, and a reset-free array maps to plain RAM.
    always_ff @(posedge clk_in) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_stream_drain.sv
// ---------------------------------------------------------------------------
// fifo_stream_drain
//   Read-side consumer of fifo_mem. Issues trans_read pops, captures the
//   registered data_out one cycle later into a skid buffer, and presents the
//   buffer head as a valid/ready stream. Burst mode waits for threshold or
//   full, then drains fifo_mem to empty and re-arms.
// Ports
//   clk_in, areset_b     clock / asynchronous active-low reset
//   enable               1 = drain permitted, 0 = stop popping and flush
//   burst_mode           wait for threshold/full, then drain to empty
//   fifo_empty_ind       fifo_mem status inputs (registered in fifo_mem)
//   fifo_full_ind
//   fifo_threshold_ind
//   fifo_underflow_ind
//   fifo_data_out        fifo_mem read data, valid the cycle after a pop
//   fifo_trans_read      pop request to fifo_mem
//   m_valid/m_ready      stream handshake; m_data is the buffer head
//   busy                 controller active or words buffered/in flight
//   word_cnt             accepted stream words, wraps silently
//   underflow_err        sticky fifo_mem underflow flag
// ---------------------------------------------------------------------------
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  enable,
    input  logic                  burst_mode,
    input  logic                  fifo_empty_ind,
    input  logic                  fifo_full_ind,
    input  logic                  fifo_threshold_ind,
    input  logic                  fifo_underflow_ind,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_trans_read,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  underflow_err
);

    localparam int OCC_W = occ_width(SKID_DEPTH);
    localparam int LVL_W = OCC_W + 1;

    drain_state_e          r_state;
    logic                  r_burst;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_underflow_err;

    logic [OCC_W-1:0]      w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_m_valid;
    logic                  w_deq;
    logic                  w_pop;
    logic [LVL_W-1:0]      w_level;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_in      (clk_in),
        .areset_b    (areset_b),
        .i_push      (r_inflight),
        .i_push_data (fifo_data_out),
        .i_pop       (w_deq),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    assign w_m_valid = (w_occ != '0);
    assign w_deq     = w_m_valid & m_ready;

    // Words that will occupy the buffer after this edge: held + arriving -
    // leaving. A new pop is allowed only if its word is guaranteed a slot.
    assign w_level = LVL_W'(w_occ) + LVL_W'(r_inflight) - LVL_W'(w_deq);
    assign w_pop   = (r_state == RUN) & ~fifo_empty_ind
                   & (w_level < LVL_W'(SKID_DEPTH));

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            r_state         <= IDLE;
            r_burst         <= 1'b0;
            r_inflight      <= 1'b0;
            r_word_cnt      <= '0;
            r_underflow_err <= 1'b0;
        end else begin
            // fifo_mem presents the popped word one cycle after the pop.
            r_inflight <= w_pop;

            if (w_deq)              r_word_cnt      <= r_word_cnt + CNT_WIDTH'(1);
            if (fifo_underflow_ind) r_underflow_err <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (enable & (~burst_mode | fifo_threshold_ind | fifo_full_ind)) begin
                        r_state <= RUN;
                        r_burst <= burst_mode;
                    end
                end
                RUN: begin
                    if (~enable)
                        r_state <= FLUSH;
                    else if (r_burst & fifo_empty_ind & ~r_inflight)
                        r_state <= IDLE;
                end
                FLUSH: begin
                    // A burst in progress is not resumed; it re-arms from IDLE.
                    if (enable & ~r_burst)
                        r_state <= RUN;
                    else if ((w_occ == '0) & ~r_inflight)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_trans_read = w_pop;
    assign m_valid         = w_m_valid;
    // Gated so m_data reads 0 whenever no word is held (including reset).
    assign m_data          = w_m_valid ? w_head : '0;
    assign busy            = (r_state != IDLE) | w_m_valid | r_inflight;
    assign word_cnt        = r_word_cnt;
    assign underflow_err   = r_underflow_err;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_drain
//   Drives fifo_stream_drain from a behavioural fifo_mem (16 deep, threshold
//   at 8). Every word written into fifo_mem is pushed into an expected queue;
//   a monitor pops and compares on each accepted stream handshake.
//   CNT_WIDTH is set to 8 so the word counter wrap is reached quickly.
// ---------------------------------------------------------------------------
module tb_fifo_stream_drain;

    localparam int DW = 16;
    localparam int SD = 2;
    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          areset_b;
    logic          enable;
    logic          burst_mode;
    logic          fifo_empty_ind;
    logic          fifo_full_ind;
    logic          fifo_threshold_ind;
    logic          fifo_underflow_ind;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_trans_read;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] word_cnt;
    logic          underflow_err;

    fifo_stream_drain #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (SD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_in             (clk_in),
        .areset_b           (areset_b),
        .enable             (enable),
        .burst_mode         (burst_mode),
        .fifo_empty_ind     (fifo_empty_ind),
        .fifo_full_ind      (fifo_full_ind),
        .fifo_threshold_ind (fifo_threshold_ind),
        .fifo_underflow_ind (fifo_underflow_ind),
        .fifo_data_out      (fifo_data_out),
        .fifo_trans_read    (fifo_trans_read),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_data             (m_data),
        .busy               (busy),
        .word_cnt           (word_cnt),
        .underflow_err      (underflow_err)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural fifo_mem ----------------
    logic [DW-1:0] fm_mem [16];
    logic [3:0]    fm_wp = '0;
    logic [3:0]    fm_rp = '0;
    logic [4:0]    fm_cnt = '0;
    int            fm_popped = 0;
    logic          fm_pop;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    assign fm_pop             = fifo_trans_read && (fm_cnt != 5'd0);
    assign fifo_empty_ind     = (fm_cnt == 5'd0);
    assign fifo_full_ind      = (fm_cnt == 5'd16);
    assign fifo_threshold_ind = (fm_cnt >= 5'd8);

    always @(posedge clk_in) begin
        if (wr_en) begin
            fm_mem[fm_wp] <= wr_data;
            fm_wp         <= fm_wp + 4'd1;
        end
        if (fm_pop) begin
            fifo_data_out <= fm_mem[fm_rp];
            fm_rp         <= fm_rp + 4'd1;
            fm_popped     <= fm_popped + 1;
        end
        fm_cnt <= fm_cnt + 5'(wr_en) - 5'(fm_pop);
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    int            delivered  = 0;
    int            lost_total = 0;
    int            max_out    = 0;
    int            first_hs   = -1;
    int            last_hs    = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (!areset_b) begin
            prev_stall = 1'b0;
        end else begin
            if (fm_popped - delivered - lost_total > max_out)
                max_out = fm_popped - delivered - lost_total;
            if (fifo_trans_read)
                check("pop_while_empty", 32'(fifo_empty_ind), 32'd0);
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: actual 0x%0h, required no word", m_data);
                end else begin
                    check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                delivered++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic write_seq(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + DW'(i);
            exp_q.push_back(wr_data);
            step(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_not_busy(input string name, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int en_cyc;
        int p0;
        int lost;

        areset_b           = 1'b0;
        enable             = 1'b0;
        burst_mode         = 1'b0;
        fifo_underflow_ind = 1'b0;
        m_ready            = 1'b1;
        step(2);

        check("rst_m_valid",   32'(m_valid),         32'd0);
        check("rst_trans_rd",  32'(fifo_trans_read), 32'd0);
        check("rst_busy",      32'(busy),            32'd0);
        check("rst_word_cnt",  32'(word_cnt),        32'd0);
        check("rst_underflow", 32'(underflow_err),   32'd0);
        check("rst_m_data",    32'(m_data),          32'd0);
        areset_b = 1'b1;
        step(1);

        // 1: 15 words at full rate
        write_seq(16'h0001, 15);
        en_cyc = cyc;
        enable = 1'b1;
        wait_drain("t1_drain", 60);
        check("t1_startup", 32'(first_hs - en_cyc), 32'd3);
        check("t1_rate",    32'(last_hs - first_hs), 32'd14);
        check("t1_word_cnt", 32'(word_cnt), 32'd15);
        enable = 1'b0;
        wait_not_busy("t1_busy_fall", 20);

        // 2: sink toggles ready every cycle
        write_seq(16'h0101, 15);
        enable = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            m_ready = ~m_ready;
            step(1);
        end
        m_ready = 1'b1;
        wait_drain("t2_drain", 20);
        check("t2_max_outstanding", 32'(max_out <= SD), 32'd1);
        check("t2_word_cnt", 32'(word_cnt), 32'd30);
        enable = 1'b0;
        wait_not_busy("t2_busy_fall", 20);

        // 3: burst mode waits for threshold, then drains to empty
        burst_mode = 1'b1;
        enable     = 1'b1;
        p0         = fm_popped;
        write_seq(16'h0201, 7);
        step(5);
        check("t3_no_pop_below_thr", 32'(fm_popped - p0), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd0);
        write_seq(16'h0208, 1);
        wait_drain("t3_drain", 40);
        wait_not_busy("t3_busy_fall", 20);
        check("t3_fifo_empty", 32'(fm_cnt), 32'd0);
        check("t3_word_cnt", 32'(word_cnt), 32'd38);

        // 4: drop enable with two words buffered
        enable     = 1'b0;
        step(1);
        burst_mode = 1'b0;
        enable     = 1'b1;
        m_ready    = 1'b0;
        write_seq(16'h0301, 6);
        step(4);
        check("t4_held", 32'(fm_popped - delivered - lost_total), 32'd2);
        check("t4_head", 32'(m_data), 32'h0301);
        enable = 1'b0;
        p0     = fm_popped;
        step(2);
        m_ready = 1'b1;
        wait_not_busy("t4_flush_idle", 20);
        check("t4_no_pop_in_flush", 32'(fm_popped - p0), 32'd0);
        check("t4_left_in_fifo", 32'(fm_cnt), 32'd4);
        check("t4_left_expected", 32'(exp_q.size()), 32'd4);
        check("t4_word_cnt", 32'(word_cnt), 32'd40);
        enable = 1'b1;
        wait_drain("t4_resume_drain", 30);
        check("t4_resume_cnt", 32'(word_cnt), 32'd44);

        // 6: one-cycle underflow pulse while streaming
        write_seq(16'h0601, 3);
        fifo_underflow_ind = 1'b1;
        step(1);
        fifo_underflow_ind = 1'b0;
        check("t6_underflow_set", 32'(underflow_err), 32'd1);
        write_seq(16'h0604, 3);
        wait_drain("t6_drain", 30);
        check("t6_underflow_sticky", 32'(underflow_err), 32'd1);
        check("t6_word_cnt", 32'(word_cnt), 32'd50);

        // 5: reset with words buffered
        m_ready = 1'b0;
        write_seq(16'h0501, 4);
        step(4);
        areset_b = 1'b0;
        #1;
        check("t5_m_valid",   32'(m_valid),         32'd0);
        check("t5_word_cnt",  32'(word_cnt),        32'd0);
        check("t5_trans_rd",  32'(fifo_trans_read), 32'd0);
        check("t5_underflow", 32'(underflow_err),   32'd0);
        lost = fm_popped - delivered - lost_total;
        check("t5_lost_words", 32'(lost), 32'd2);
        for (int i = 0; i < lost && exp_q.size() != 0; i++) exp_q.delete(0);
        lost_total += lost;
        step(2);
        areset_b = 1'b1;
        m_ready  = 1'b1;
        wait_drain("t5_resume_drain", 30);
        check("t5_word_cnt_after", 32'(word_cnt), 32'd2);

        // word counter wrap (8-bit instance)
        write_seq(16'h1000, 253);
        wait_drain("wrap_fill_drain", 40);
        check("wrap_at_max", 32'(word_cnt), 32'd255);
        write_seq(16'h2000, 1);
        wait_drain("wrap_last_drain", 20);
        check("wrap_to_zero", 32'(word_cnt), 32'd0);

        enable = 1'b0;
        wait_not_busy("final_idle", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
